// File: rtl/mips_run_controller.sv
// Run/dump sequencer for mips_core: holds the core in reset, runs it for a
// programmed number of enabled cycles, then streams a data-memory word range
// out on a valid/ready interface through the single memory read port.
module mips_run_controller #(
  parameter int N          = 32,
  parameter int AW         = 10,
  parameter int CW         = 32,
  parameter int RESET_HOLD = 2
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] num_cycles,
  input  logic [AW:0]   dump_start,
  input  logic [AW:0]   dump_stop,
  output logic          core_rstb,
  output logic          core_ena,
  output logic          dmem_rd_ena,
  output logic [AW-1:0] dmem_addr,
  input  logic [N-1:0]  dmem_rd_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [N-1:0]  dump_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_count
);

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [HW-1:0] HW_ONE    = 1;
  localparam logic [CW-1:0] CW_ONE    = 1;
  localparam logic [AW:0]   PTR_ONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] lat_cycles;
  logic [AW:0]   lat_start;
  logic [AW:0]   lat_stop;
  logic [AW:0]   ptr;
  logic [AW:0]   ptr_inc;
  logic [HW-1:0] hold_cnt;
  logic          hold_last;
  logic          run_last;
  logic          range_ok;
  logic          start_ok;
  logic          load_ptr;
  logic          advance;

  assign ptr_inc   = ptr + PTR_ONE;
  assign hold_last = (hold_cnt == HOLD_LAST);
  assign run_last  = ((cycle_count + CW_ONE) == lat_cycles);
  // A start address beyond the memory is treated as an empty range.
  assign range_ok  = (lat_stop > lat_start) && !lat_start[AW];

  // Outputs are pure state decodes (plus the registered pointer/data).
  assign core_rstb   = !(state == S_IDLE || state == S_HOLD);
  assign core_ena    = (state == S_RUN);
  assign dmem_rd_ena = (state == S_DUMP_RD);
  assign dmem_addr   = ptr[AW-1:0];
  assign dump_valid  = (state == S_DUMP_OUT);
  assign busy        = !(state == S_IDLE || state == S_DONE);
  assign done        = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath strobes; abort overrides everything.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    load_ptr  = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_last) begin
          if (lat_cycles == '0) begin
            load_ptr  = range_ok;
            state_nxt = range_ok ? S_DUMP_RD : S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (run_last) begin
          load_ptr  = range_ok;
          state_nxt = range_ok ? S_DUMP_RD : S_DONE;
        end
      end
      S_DUMP_RD:  state_nxt = S_DUMP_CAP;
      S_DUMP_CAP: state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (dump_ready) begin
          advance   = 1'b1;
          state_nxt = (ptr_inc == lat_stop) ? S_DONE : S_DUMP_RD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      start_ok  = 1'b0;
      load_ptr  = 1'b0;
      advance   = 1'b0;
    end
  end

  // Latched run parameters, hold/cycle counters and the dump pointer.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lat_cycles  <= '0;
      lat_start   <= '0;
      lat_stop    <= '0;
      cycle_count <= '0;
      hold_cnt    <= '0;
      ptr         <= '0;
    end else begin
      if (start_ok) begin
        lat_cycles  <= num_cycles;
        lat_start   <= dump_start;
        lat_stop    <= dump_stop;
        cycle_count <= '0;
        hold_cnt    <= '0;
      end
      if (state == S_HOLD && !hold_last) begin
        hold_cnt <= hold_cnt + HW_ONE;
      end
      if (state == S_RUN) begin
        cycle_count <= cycle_count + CW_ONE;
      end
      if (load_ptr) begin
        ptr <= lat_start;
      end else if (advance) begin
        ptr <= ptr_inc;
      end
    end
  end

  // Capture the read word one cycle after the strobe; held until handshake.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dump_data <= '0;
      dump_addr <= '0;
    end else if (state == S_DUMP_CAP) begin
      dump_data <= dmem_rd_data;
      dump_addr <= ptr[AW-1:0];
    end
  end

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller with a registered-read memory model
// and an address/data scoreboard on the dump stream.
module tb_mips_run_controller;

  localparam int N  = 32;
  localparam int AW = 4;
  localparam int CW = 32;
  localparam int RH = 2;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start;
  logic          abort;
  logic [CW-1:0] num_cycles;
  logic [AW:0]   dump_start;
  logic [AW:0]   dump_stop;
  logic          core_rstb;
  logic          core_ena;
  logic          dmem_rd_ena;
  logic [AW-1:0] dmem_addr;
  logic [N-1:0]  dmem_rd_data = '0;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int n_ena, n_hold, n_busy, n_dump, n_vld, n_hs;
  logic [AW-1:0] q_addr[$];
  logic [N-1:0]  q_data[$];
  logic          stall_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [N-1:0]  prev_data;

  mips_run_controller #(.N(N), .AW(AW), .CW(CW), .RESET_HOLD(RH)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .num_cycles(num_cycles), .dump_start(dump_start), .dump_stop(dump_stop),
    .core_rstb(core_rstb), .core_ena(core_ena), .dmem_rd_ena(dmem_rd_ena),
    .dmem_addr(dmem_addr), .dmem_rd_data(dmem_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Data memory: word[k] = k*4 + 0x100, read data one cycle after strobe.
  always @(posedge clk) begin
    if (dmem_rd_ena) dmem_rd_data <= 32'h100 + {28'b0, dmem_addr} * 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle counters, backpressure stability and scoreboard on the dump stream.
  always @(negedge clk) begin
    if (rstb) begin
      if (core_ena) n_ena++;
      if (busy && !core_rstb) n_hold++;
      if (busy) n_busy++;
      if (busy && core_rstb && !core_ena) n_dump++;
      if (dump_valid) n_vld++;
      if (stall_prev) begin
        chk("stall_valid", dump_valid, 1);
        chk("stall_addr", dump_addr, prev_addr);
        chk("stall_data", dump_data, prev_data);
      end
      if (dump_valid && dump_ready) begin
        n_hs++;
        chk("sb_word_expected", q_addr.size() > 0, 1);
        if (q_addr.size() > 0) begin
          chk("sb_addr", dump_addr, q_addr.pop_front());
          chk("sb_data", dump_data, q_data.pop_front());
        end
      end
      stall_prev = dump_valid && !dump_ready;
      prev_addr  = dump_addr;
      prev_data  = dump_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic run_start(input logic [CW-1:0] nc, input int s, input int e);
    @(posedge clk); #1;
    num_cycles = nc;
    dump_start = (AW+1)'(s);
    dump_stop  = (AW+1)'(e);
    start      = 1'b1;
    n_ena = 0; n_hold = 0; n_busy = 0; n_dump = 0; n_vld = 0; n_hs = 0;
    if (s < (1 << AW) && e > s) begin
      for (int k = s; k < e; k++) begin
        q_addr.push_back(AW'(k));
        q_data.push_back(32'h100 + 32'(k) * 32'd4);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(tag, done, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dump_valid) break;
    end
    chk(tag, dump_valid, 1);
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b1;
    num_cycles = '0; dump_start = '0; dump_stop = '0;
    repeat (2) @(negedge clk);
    chk("rst_core_rstb", core_rstb, 0);
    chk("rst_core_ena", core_ena, 0);
    chk("rst_rd_ena", dmem_rd_ena, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dump_addr", dump_addr, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_cycle_count", cycle_count, 0);
    @(posedge clk); #1 rstb = 1'b1;

    // Run 5 cycles, empty dump range.
    run_start(5, 0, 0);
    wait_done("t1_done", 100);
    chk("t1_hold_cycles", n_hold, 2);
    chk("t1_ena_cycles", n_ena, 5);
    chk("t1_cycle_count", cycle_count, 5);
    chk("t1_no_valid", n_vld, 0);
    chk("t1_done_core_rstb", core_rstb, 1);
    chk("t1_done_core_ena", core_ena, 0);

    // Dump 4..8 with ready held high.
    run_start(3, 4, 8);
    wait_done("t2_done", 100);
    chk("t2_handshakes", n_hs, 4);
    chk("t2_sb_empty", q_addr.size(), 0);
    chk("t2_busy_cycles", n_busy, 17);
    chk("t2_dump_cycles", n_dump, 12);
    chk("t2_ena_cycles", n_ena, 3);

    // Same range with ready toggling every cycle.
    dump_ready = 1'b0;
    run_start(3, 4, 8);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      dump_ready = ~dump_ready;
      if (done) break;
    end
    chk("t3_done", done, 1);
    chk("t3_handshakes", n_hs, 4);
    chk("t3_sb_empty", q_addr.size(), 0);
    dump_ready = 1'b1;

    // Zero run length, single word at address 0.
    run_start(0, 0, 1);
    wait_done("t4_done", 100);
    chk("t4_ena_cycles", n_ena, 0);
    chk("t4_hold_cycles", n_hold, 2);
    chk("t4_handshakes", n_hs, 1);
    chk("t4_sb_empty", q_addr.size(), 0);

    // Top of memory: 14..16 with no wrap.
    run_start(2, 14, 16);
    wait_done("t5_done", 100);
    chk("t5_handshakes", n_hs, 2);
    chk("t5_sb_empty", q_addr.size(), 0);
    chk("t5_dump_cycles", n_dump, 6);

    // Start address beyond memory: nothing dumped.
    run_start(2, 16, 20);
    wait_done("t5b_done", 100);
    chk("t5b_no_valid", n_vld, 0);

    // Abort during RUN at cycle_count 3.
    run_start(10, 0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_ena && cycle_count == 3) break;
    end
    chk("t6_reach_cc3", cycle_count, 3);
    abort = 1'b1;
    @(negedge clk);
    chk("t6_core_rstb", core_rstb, 0);
    chk("t6_core_ena", core_ena, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    abort = 1'b0;

    // Start while in DUMP_OUT is ignored.
    dump_ready = 1'b0;
    run_start(2, 4, 6);
    wait_valid("t7_valid", 100);
    @(posedge clk); #1;
    num_cycles = 7; dump_start = '0; dump_stop = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t7_still_valid", dump_valid, 1);
    chk("t7_still_busy", busy, 1);
    chk("t7_addr", dump_addr, 4);
    chk("t7_cycle_count", cycle_count, 2);
    dump_ready = 1'b1;
    wait_done("t7_done", 100);
    chk("t7_handshakes", n_hs, 2);
    chk("t7_sb_empty", q_addr.size(), 0);

    // Asynchronous reset mid-dump.
    dump_ready = 1'b0;
    run_start(1, 3, 8);
    wait_valid("t8_valid", 100);
    @(negedge clk); #2;
    rstb = 1'b0;
    #1;
    chk("t8_core_rstb", core_rstb, 0);
    chk("t8_core_ena", core_ena, 0);
    chk("t8_valid", dump_valid, 0);
    chk("t8_busy", busy, 0);
    chk("t8_done", done, 0);
    chk("t8_dump_addr", dump_addr, 0);
    chk("t8_dump_data", dump_data, 0);
    chk("t8_cycle_count", cycle_count, 0);
    q_addr.delete();
    q_data.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rstb = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    chk("t8_idle_busy", busy, 0);
    chk("t8_idle_core_rstb", core_rstb, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
